// File: rtl/featuremap_pkg.sv
// Shared definitions for the conv2d_3 feature-map frame sequencer:
// state encoding and frame-geometry helpers.
package featuremap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Input frame carries a one-pixel zero border on every side.
    function automatic int in_pix(input int width);
        return (width + 2) * (width + 2);
    endfunction

    function automatic int out_pix(input int width);
        return width * width;
    endfunction

endpackage

// File: rtl/featuremap_frame_counter.sv
// Saturating frame pixel counter with synchronous clear and a flag that
// is high once the count has reached its terminal value.
module featuremap_frame_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_reg;

    assign at_max = (count_reg == W'(MAX));
    assign count  = count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && !at_max) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/featuremap_stream_ctrl.sv
// Frame sequencer for one conv2d_3 feature map: issues aligned reads across
// all channel FIFOs, counts pixels in and out, and reports frame status.
module featuremap_stream_ctrl
    import featuremap_pkg::*;
#(
    parameter int  NUM_CH    = 16,
    parameter int  WIDTH     = 56,
    parameter int  DRAIN_MAX = 256,
    localparam int IN_PIX    = in_pix(WIDTH),
    localparam int OUT_PIX   = out_pix(WIDTH),
    localparam int CNT_W     = clog2(IN_PIX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic              out_ready,
    input  logic              conv_valid,
    output logic              rdreq,
    output logic              conv_valid_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [CNT_W-1:0]  out_cnt
);

    localparam int TMR_W = clog2(DRAIN_MAX + 1);

    state_t             state_reg, state_next;
    logic               error_reg, error_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic               all_avail;
    logic               frame_start;
    logic               out_en;
    logic               in_full, out_full;
    logic               last_read, out_last, timeout;

    assign all_avail     = ~|fifo_empty;
    // Reads are shared so every channel consumes the same pixel together.
    assign rdreq         = (state_reg == RUN) && all_avail && out_ready && !in_full;
    assign conv_valid_in = rdreq;
    assign frame_start   = (state_reg == IDLE) && start;
    assign out_en        = conv_valid && ((state_reg == RUN) || (state_reg == DRAIN));

    assign busy  = (state_reg == RUN) || (state_reg == DRAIN);
    assign done  = (state_reg == DONE);
    assign error = error_reg;

    assign last_read = rdreq && (in_cnt == CNT_W'(IN_PIX - 1));
    assign out_last  = out_full || (conv_valid && (out_cnt == CNT_W'(OUT_PIX - 1)));
    assign timeout   = !conv_valid && (timer_reg == TMR_W'(DRAIN_MAX - 1));

    featuremap_frame_counter #(.W(CNT_W), .MAX(IN_PIX)) u_in_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (frame_start),
        .en     (rdreq),
        .count  (in_cnt),
        .at_max (in_full)
    );

    featuremap_frame_counter #(.W(CNT_W), .MAX(OUT_PIX)) u_out_counter (
        .clk    (clk),
        .rst    (rst),
        .clr    (frame_start),
        .en     (out_en),
        .count  (out_cnt),
        .at_max (out_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            error_reg <= 1'b0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            error_reg <= error_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        error_next = error_reg;
        timer_next = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    error_next = 1'b0;
                end else if (conv_valid) begin
                    error_next = 1'b1;
                end
            end
            RUN: begin
                if (last_read) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Timer measures the gap since the last result, not total drain time.
                timer_next = conv_valid ? '0 : timer_reg + 1'b1;
                if (conv_valid && out_full) begin
                    error_next = 1'b1;
                end
                if (out_last) begin
                    state_next = DONE;
                end else if (timeout) begin
                    error_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
